// File: rtl/btb_predictor_if.sv
// Fetch-lookup / EX-update / flush bundle for btb_predictor.
interface btb_predictor_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_is_jump;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        btb_flush;
    logic [31:0] mispred_cnt;

    modport slave (
        input  if_valid, if_pc, upd_valid, upd_pc, upd_taken, upd_is_jump,
               upd_target, upd_mispredict, btb_flush,
        output pred_taken, pred_target, mispred_cnt
    );

    modport master (
        output if_valid, if_pc, upd_valid, upd_pc, upd_taken, upd_is_jump,
               upd_target, upd_mispredict, btb_flush,
        input  pred_taken, pred_target, mispred_cnt
    );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Define BTB_FWD_EN to forward a same-cycle update into the lookup path.
module btb_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    btb_predictor_if.slave  bus
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] tag;
        logic [31:0]   tgt;
        logic [1:0]    ctr;
    } entry_t;

    entry_t [ENTRIES-1:0] tbl_q;
    logic [31:0]          mispred_cnt_q, mispred_cnt_d;

    logic [IW-1:0] upd_idx, lk_idx;
    logic [TW-1:0] upd_tag, lk_tag;
    entry_t        upd_cur, upd_ent_d, lk_ent;
    logic          upd_hit, upd_we, lk_hit;
    logic          unused_bits;

    assign upd_idx     = bus.upd_pc[IW+1:2];
    assign upd_tag     = bus.upd_pc[31:IW+2];
    assign lk_idx      = bus.if_pc[IW+1:2];
    assign lk_tag      = bus.if_pc[31:IW+2];
    assign upd_cur     = tbl_q[upd_idx];
    assign upd_hit     = upd_cur.valid && (upd_cur.tag == upd_tag);
    assign unused_bits = ^{bus.upd_pc[1:0], bus.upd_target[0]};

    // Next value of the entry addressed by the update port.
    always_comb begin
        upd_ent_d = upd_cur;
        upd_we    = 1'b0;
        if (bus.upd_valid) begin
            if (upd_hit) begin
                upd_we = 1'b1;
                if (bus.upd_taken) begin
                    if (upd_cur.ctr != 2'd3) upd_ent_d.ctr = upd_cur.ctr + 2'd1;
                    upd_ent_d.tgt = {bus.upd_target[31:1], 1'b0};
                end else if (upd_cur.ctr != 2'd0) begin
                    upd_ent_d.ctr = upd_cur.ctr - 2'd1;
                end
                if (bus.upd_is_jump) upd_ent_d.ctr = 2'd3;
            end else if (bus.upd_taken) begin
                upd_we          = 1'b1;
                upd_ent_d.valid = 1'b1;
                upd_ent_d.tag   = upd_tag;
                upd_ent_d.tgt   = {bus.upd_target[31:1], 1'b0};
                upd_ent_d.ctr   = bus.upd_is_jump ? 2'd3 : 2'd2;
            end
        end
    end

`ifdef BTB_FWD_EN
    // Blocks forwarding of an update still pending from inside reset.
    logic fwd_ok_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fwd_ok_q <= 1'b0;
        else        fwd_ok_q <= 1'b1;
    end

    always_comb begin
        lk_ent = tbl_q[lk_idx];
        if (fwd_ok_q && upd_we && (upd_idx == lk_idx)) lk_ent = upd_ent_d;
        if (bus.btb_flush) lk_ent.valid = 1'b0;
    end
`else
    assign lk_ent = tbl_q[lk_idx];
`endif

    assign lk_hit          = bus.if_valid && lk_ent.valid && (lk_ent.tag == lk_tag);
    assign bus.pred_taken  = lk_hit && lk_ent.ctr[1];
    assign bus.pred_target = bus.pred_taken ? lk_ent.tgt : bus.if_pc + 32'd4;
    assign bus.mispred_cnt = mispred_cnt_q;

    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        if (bus.upd_valid && bus.upd_mispredict && (mispred_cnt_q != 32'hFFFF_FFFF))
            mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid <= 1'b0;
                tbl_q[i].tag   <= '0;
                tbl_q[i].tgt   <= '0;
                tbl_q[i].ctr   <= 2'd1;
            end
            mispred_cnt_q <= '0;
        end else begin
            // Flush discards any same-cycle table update.
            if (bus.btb_flush) begin
                for (int i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
            end else if (upd_we) begin
                tbl_q[upd_idx] <= upd_ent_d;
            end
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Randomized bench for btb_predictor against a PC-keyed behavioural model.
module tb_btb_predictor;
    localparam int ENT = 16;
    localparam int IW  = $clog2(ENT);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    btb_predictor_if bus ();
    btb_predictor #(.ENTRIES(ENT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errs   = 0;
    int checks = 0;

    // Model: each slot remembers the full PC that allocated it.
    bit          mv  [ENT];
    bit [31:0]   mpc [ENT];
    bit [31:0]   mtg [ENT];
    int          mct [ENT];
    bit [31:0]   mcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < ENT; i++) begin
            mv[i] = 0; mpc[i] = 0; mtg[i] = 0; mct[i] = 1;
        end
        mcnt = 0;
    endfunction

    function automatic bit same_line(input bit [31:0] a, input bit [31:0] b);
        return (a / (4 * ENT)) == (b / (4 * ENT));
    endfunction

    function automatic void upd_result(output int idx, output bit we, output bit nv,
                                       output bit [31:0] npc, output bit [31:0] ntg,
                                       output int nct);
        idx = (bus.upd_pc / 4) % ENT;
        we = 0; nv = mv[idx]; npc = mpc[idx]; ntg = mtg[idx]; nct = mct[idx];
        if (!bus.upd_valid) return;
        if (mv[idx] && same_line(mpc[idx], bus.upd_pc)) begin
            we = 1;
            if (bus.upd_taken) begin
                nct = (nct + 1 > 3) ? 3 : nct + 1;
                ntg = bus.upd_target & 32'hFFFF_FFFE;
            end else begin
                nct = (nct - 1 < 0) ? 0 : nct - 1;
            end
            if (bus.upd_is_jump) nct = 3;
        end else if (bus.upd_taken) begin
            we = 1; nv = 1; npc = bus.upd_pc;
            ntg = bus.upd_target & 32'hFFFF_FFFE;
            nct = bus.upd_is_jump ? 3 : 2;
        end
    endfunction

    function automatic void m_expect(output bit pt, output bit [31:0] tg);
        int idx, ui, nct, c;
        bit we, nv, v;
        bit [31:0] npc, ntg, p, t;
        pt = 0;
        tg = bus.if_pc + 32'd4;
        if (!rst_n || !bus.if_valid) return;
        idx = (bus.if_pc / 4) % ENT;
        v = mv[idx]; p = mpc[idx]; t = mtg[idx]; c = mct[idx];
`ifdef BTB_FWD_EN
        upd_result(ui, we, nv, npc, ntg, nct);
        if (bus.btb_flush) v = 0;
        else if (we && ui == idx) begin
            v = nv; p = npc; t = ntg; c = nct;
        end
`endif
        if (v && same_line(p, bus.if_pc) && c >= 2) begin
            pt = 1;
            tg = t;
        end
    endfunction

    function automatic void m_apply();
        int ui, nct;
        bit we, nv;
        bit [31:0] npc, ntg;
        upd_result(ui, we, nv, npc, ntg, nct);
        if (bus.btb_flush) begin
            for (int i = 0; i < ENT; i++) mv[i] = 0;
        end else if (we) begin
            mv[ui] = nv; mpc[ui] = npc; mtg[ui] = ntg; mct[ui] = nct;
        end
        if (bus.upd_valid && bus.upd_mispredict && mcnt != 32'hFFFF_FFFF) mcnt++;
    endfunction

    task automatic step(input string tag);
        bit pt;
        bit [31:0] tg;
        @(negedge clk);
        m_expect(pt, tg);
        chk({tag, "_pt"},  {31'd0, bus.pred_taken}, {31'd0, pt});
        chk({tag, "_tgt"}, bus.pred_target, tg);
        chk({tag, "_cnt"}, bus.mispred_cnt, mcnt);
        @(posedge clk);
        if (rst_n) m_apply();
        #1;
    endtask

    task automatic idle();
        bus.upd_valid = 0; bus.upd_taken = 0; bus.upd_is_jump = 0;
        bus.upd_mispredict = 0; bus.btb_flush = 0;
    endtask

    task automatic upd(input bit [31:0] pc, input bit tk, input bit jmp, input bit [31:0] tgt);
        bus.upd_valid = 1; bus.upd_pc = pc; bus.upd_taken = tk;
        bus.upd_is_jump = jmp; bus.upd_target = tgt;
    endtask

    task automatic look(input bit [31:0] pc);
        bus.if_valid = 1; bus.if_pc = pc;
    endtask

    initial begin
        bit pt;
        bit [31:0] tg;
        rst_n = 0;
        idle();
        bus.upd_pc = 0; bus.upd_target = 0;
        look(32'h100);
        m_reset();
        upd(32'h100, 1, 0, 32'h200);            // must be discarded by reset
        step("rst");
        chk("rst_pt0", {31'd0, bus.pred_taken}, 32'd0);
        chk("rst_tgt104", bus.pred_target, 32'h104);
        rst_n = 1; idle();
        step("post_rst");

        upd(32'h100, 1, 0, 32'h200); step("alloc");
        idle(); step("hit");
        upd(32'h100, 0, 0, 32'h0); step("nt1");
        step("nt2");
        idle(); step("nt_done");

        upd(32'h100, 1, 0, 32'h200); step("alias_a");
        upd(32'h140, 1, 0, 32'h300); step("alias_b");
        idle(); step("alias_lk100");
        look(32'h140); step("alias_lk140");

        look(32'h80); upd(32'h80, 1, 0, 32'h40); step("fwd");
        idle(); step("fwd_next");

        upd(32'h100, 1, 0, 32'h200); bus.btb_flush = 1; step("flush");
        idle(); step("flush_lk80");
        look(32'h100); step("flush_lk100");
        look(32'h140); step("flush_lk140");

        upd(32'h500, 0, 0, 32'h0); bus.upd_mispredict = 1;
        step("mp1"); step("mp2"); step("mp3");
        idle(); step("mp_done");
        chk("mp_cnt3", bus.mispred_cnt, 32'd3);

        look(32'hFFFF_FFFC); step("wrap");

        upd(32'h100, 0, 1, 32'h181); step("jmp_alloc_nt");
        upd(32'h100, 1, 1, 32'h181); step("jmp_alloc");
        idle(); look(32'h100); step("jmp_hit");
        #2;
        m_expect(pt, tg);
        chk("pre_async_pt", {31'd0, bus.pred_taken}, {31'd0, pt});
        rst_n = 0; m_reset();
        #1;
        chk("async_pt", {31'd0, bus.pred_taken}, 32'd0);
        chk("async_tgt", bus.pred_target, 32'h104);
        chk("async_cnt", bus.mispred_cnt, 32'd0);
        upd(32'h100, 1, 0, 32'h200);
        step("in_rst");
        rst_n = 1; idle();
        step("after_rst2");

        for (int n = 0; n < 3000; n++) begin
            bus.if_valid = ($urandom_range(0, 9) != 0);
            bus.if_pc = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom_range(0, 127) << 2);
            bus.upd_valid = $urandom_range(0, 1);
            bus.upd_pc = ($urandom_range(0, 127) << 2);
            if ($urandom_range(0, 1) == 0) bus.upd_pc = bus.if_pc;
            bus.upd_taken = $urandom_range(0, 1);
            bus.upd_is_jump = ($urandom_range(0, 3) == 0);
            bus.upd_target = $urandom();
            bus.upd_mispredict = ($urandom_range(0, 3) == 0);
            bus.btb_flush = ($urandom_range(0, 39) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning number of direct-mapped BTB entries (power of two, 4..256).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port if_valid  input  1  fetch lookup request valid.
REQ-005 SHALL have port if_pc  input  32  fetch PC to look up.
REQ-006 SHALL have port pred_taken  output  1  predict taken for if_pc.
REQ-007 SHALL have port pred_target  output  32  predicted next PC.
REQ-008 SHALL have port upd_valid  input  1  EX resolved a branch/jump this cycle.
REQ-009 SHALL have port upd_pc  input  32  PC of resolved instruction.
REQ-010 SHALL have port upd_taken  input  1  resolved outcome taken.
REQ-011 SHALL have port upd_is_jump  input  1  resolved instruction is JAL/JALR.
REQ-012 SHALL have port upd_target  input  32  resolved jump/branch address.
REQ-013 SHALL have port upd_mispredict  input  1  EX redirected the PC (prediction wrong).
REQ-014 SHALL have port btb_flush  input  1  invalidate all entries.
REQ-015 SHALL have port mispred_cnt  output  32  count of mispredicted resolutions.

Function
REQ-016 SHALL index with pc[IW+1:2] and tag with pc[31:IW+2], where IW = log2(ENTRIES).
REQ-017 SHALL hold per entry: valid (1), tag (30-IW), target (32), ctr (2-bit saturating).
REQ-018 SHALL perform lookup combinationally; hit = if_valid & valid[idx] & tag match.
REQ-019 SHALL drive pred_taken = hit & ctr[1]; pred_target = stored target if pred_taken, else if_pc+4 (mod 2^32).
REQ-020 SHALL drive pred_taken = 0 whenever if_valid = 0.
REQ-021 SHALL, on a clock edge with upd_valid and tag hit: ctr+1 saturating at 3 if upd_taken, ctr-1 saturating at 0 if not; target overwritten only when upd_taken.
REQ-022 SHALL, on upd_valid with miss and upd_taken: allocate entry (valid=1, tag, target); ctr=3 if upd_is_jump, else 2.
REQ-023 SHALL NOT allocate on miss with upd_taken = 0.
REQ-024 SHALL set ctr=3 on any hit update with upd_is_jump = 1.
REQ-025 SHALL store upd_target with bit 0 cleared.
REQ-026 SHALL, on btb_flush, clear all valid bits in one cycle; flush wins over a same-cycle update (update discarded).
REQ-027 SHALL increment mispred_cnt when upd_valid & upd_mispredict, saturating at 0xFFFFFFFF; btb_flush does not clear it.
REQ-028 SHALL ignore upd_taken, upd_is_jump, upd_target, upd_mispredict when upd_valid = 0.
REQ-029 SHALL make updates visible to lookups in the cycle after the update edge (absent REQ-034).

Reset
REQ-030 SHALL, on rst_n low, immediately clear all valid bits, set every ctr to 1, and clear mispred_cnt to 0, independent of clk.
REQ-031 SHALL hold pred_taken = 0 and pred_target = if_pc+4 while in reset.
REQ-032 SHALL discard an update coinciding with reset assertion; first update accepted on the first rising edge after rst_n rises.

Configuration
REQ-033 SHALL use macro BTB_FWD_EN to select same-cycle update forwarding.
REQ-034 SHALL, with BTB_FWD_EN defined, when upd_valid and the lookup hit the same index in one cycle, drive pred_taken/pred_target from the post-update entry value (flush still forces miss).
REQ-035 SHALL, without BTB_FWD_EN, drive lookup from pre-update state in that case.

Verification
REQ-036 Reset, if_valid=1, if_pc=0x100 -> pred_taken=0, pred_target=0x104, mispred_cnt=0.
REQ-037 Update pc=0x100, taken, is_jump=0, target=0x200; next cycle lookup 0x100 -> pred_taken=1, pred_target=0x200; two not-taken updates -> ctr=0, lookup pred_taken=0.
REQ-038 ENTRIES=16: allocate 0x100 -> 0x200, then allocate 0x140 (same index, different tag) -> 0x300; lookup 0x100 -> miss, pred_target=0x104.
REQ-039 Same-cycle update pc=0x80 taken target=0x40 with lookup 0x80: BTB_FWD_EN -> pred_taken=1, target 0x40; without -> pred_taken=0.
REQ-040 btb_flush with same-cycle update of 0x100 -> all lookups miss next cycle; three upd_mispredict pulses -> mispred_cnt=3.
REQ-041 Assert rst_n low mid-stream between edges -> pred_taken drops to 0 combinationally, mispred_cnt=0 before the next edge.
